tcb_dec_lat: RTL and testbench



---
 rtl/tcb_dec_lat.sv | 113 +++++++++++
 tb/tb_tcb_dec_lat.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tcb_dec_lat.sv
// TCB address decoder: mask/match routing of one manager onto PN subordinates,
// with an internal error responder and a DLY-deep select pipeline for responses.
module tcb_dec_lat #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int PN  = 2,
  parameter int DLY = 1,
  parameter logic [PN-1:0][AW-1:0] AS = '0,
  parameter logic [PN-1:0][AW-1:0] AM = '0
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_vld,
  input  logic                   s_wen,
  input  logic [BW-1:0]          s_ben,
  input  logic [AW-1:0]          s_adr,
  input  logic [DW-1:0]          s_wdt,
  output logic                   s_rdy,
  output logic [DW-1:0]          s_rdt,
  output logic                   s_err,
  output logic [PN-1:0]          m_vld,
  output logic                   m_wen,
  output logic [BW-1:0]          m_ben,
  output logic [AW-1:0]          m_adr,
  output logic [DW-1:0]          m_wdt,
  input  logic [PN-1:0]          m_rdy,
  input  logic [PN-1:0][DW-1:0]  m_rdt,
  input  logic [PN-1:0]          m_err
);

  localparam int SW = (PN > 1) ? $clog2(PN) : 1;

  logic [PN-1:0]  hit;
  logic [SW-1:0]  sel;
  logic           miss;
  logic           rdy_sel;
  logic           trn;

  // response pipeline: one {vld, miss, sel} slot per latency cycle
  logic [DLY-1:0]          vld_p;
  logic [DLY-1:0]          miss_p;
  logic [DLY-1:0][SW-1:0]  sel_p;

  // request decode (combinational)
  always_comb begin
    hit     = '0;
    sel     = '0;
    rdy_sel = 1'b0;
    m_vld   = '0;
    for (int i = 0; i < PN; i++) begin
      hit[i] = ((s_adr ^ AS[i]) & AM[i]) == '0;
    end
    // scan downward so the lowest matching index is the last one written
    for (int i = PN-1; i >= 0; i--) begin
      if (hit[i]) sel = SW'(i);
    end
    miss = ~|hit;
    for (int i = 0; i < PN; i++) begin
      if (sel == SW'(i)) begin
        rdy_sel  = m_rdy[i];
        m_vld[i] = s_vld & hit[i];
      end
    end
    s_rdy = miss ? 1'b1 : rdy_sel;
    trn   = s_vld & s_rdy;
  end

  assign m_wen = s_wen;
  assign m_ben = s_ben;
  assign m_adr = s_adr;
  assign m_wdt = s_wdt;

  // stage 0 captures the transfer, later stages shift every cycle (no stall)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= trn;
      for (int k = 1; k < DLY; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    miss_p[0] <= miss;
    sel_p[0]  <= sel;
    for (int k = 1; k < DLY; k++) begin
      miss_p[k] <= miss_p[k-1];
      sel_p[k]  <= sel_p[k-1];
    end
  end

  // response mux from the last stage; idle slots are forced to zero
  always_comb begin
    s_rdt = '0;
    s_err = 1'b0;
    if (vld_p[DLY-1]) begin
      if (miss_p[DLY-1]) begin
        s_err = 1'b1;
      end else begin
        for (int i = 0; i < PN; i++) begin
          if (sel_p[DLY-1] == SW'(i)) begin
            s_rdt = m_rdt[i];
            s_err = m_err[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tcb_dec_lat.sv
// Directed bench for tcb_dec_lat: PN=3, DLY=2, one port per 256 MiB region,
// plus a second instance with an overlapping map for priority checks.
module tb_tcb_dec_lat;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int PN = 3;
  localparam int DLY = 2;
  localparam logic [PN-1:0][AW-1:0] AS_T = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [PN-1:0][AW-1:0] AM_T = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [PN-1:0][AW-1:0] AM_O = {32'hF000_0000, 32'h0000_0000, 32'hF000_0000};

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_vld, s_wen;
  logic [BW-1:0]         s_ben;
  logic [AW-1:0]         s_adr;
  logic [DW-1:0]         s_wdt;
  logic                  s_rdy, s_err;
  logic [DW-1:0]         s_rdt;
  logic [PN-1:0]         m_vld;
  logic                  m_wen;
  logic [BW-1:0]         m_ben;
  logic [AW-1:0]         m_adr;
  logic [DW-1:0]         m_wdt;
  logic [PN-1:0]         m_rdy;
  logic [PN-1:0][DW-1:0] m_rdt;
  logic [PN-1:0]         m_err;

  logic                  o_rdy, o_err;
  logic [DW-1:0]         o_rdt;
  logic [PN-1:0]         o_vld;
  logic                  o_wen;
  logic [BW-1:0]         o_ben;
  logic [AW-1:0]         o_adr;
  logic [DW-1:0]         o_wdt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tcb_dec_lat #(.AW(AW), .DW(DW), .BW(BW), .PN(PN), .DLY(DLY), .AS(AS_T), .AM(AM_T)) dut (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben), .s_adr(s_adr), .s_wdt(s_wdt),
    .s_rdy(s_rdy), .s_rdt(s_rdt), .s_err(s_err),
    .m_vld(m_vld), .m_wen(m_wen), .m_ben(m_ben), .m_adr(m_adr), .m_wdt(m_wdt),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
  );

  tcb_dec_lat #(.AW(AW), .DW(DW), .BW(BW), .PN(PN), .DLY(DLY), .AS(AS_T), .AM(AM_O)) dut_o (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben), .s_adr(s_adr), .s_wdt(s_wdt),
    .s_rdy(o_rdy), .s_rdt(o_rdt), .s_err(o_err),
    .m_vld(o_vld), .m_wen(o_wen), .m_ben(o_ben), .m_adr(o_adr), .m_wdt(o_wdt),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge; caller then sets inputs, waits #1, checks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_vld = 1'b0; s_wen = 1'b0; s_ben = 4'hF; s_adr = '0; s_wdt = '0;
    m_rdy = 3'b111; m_rdt = '0; m_err = '0;

    // reset state
    cyc(); cyc();
    #1;
    chk("rst_rdt", s_rdt, 32'h0);
    chk("rst_err", {31'b0, s_err}, 32'h0);
    chk("rst_rdy", {31'b0, s_rdy}, 32'h1);
    chk("rst_mvld", {29'b0, m_vld}, 32'h0);
    cyc(); rst = 1'b0;

    // single read to port 1, response exactly two cycles later
    cyc(); s_vld = 1'b1; s_adr = 32'h1000_0004; s_wdt = 32'h1234_5678; #1;
    chk("rd1_mvld", {29'b0, m_vld}, 32'h2);
    chk("rd1_rdy", {31'b0, s_rdy}, 32'h1);
    chk("rd1_madr", m_adr, 32'h1000_0004);
    chk("rd1_mwdt", m_wdt, 32'h1234_5678);
    cyc(); s_vld = 1'b0; m_rdt[1] = 32'hDEAD_BEEF; #1;
    chk("rd1_early", s_rdt, 32'h0);
    cyc(); #1;
    chk("rd1_rdt", s_rdt, 32'hDEAD_BEEF);
    chk("rd1_err", {31'b0, s_err}, 32'h0);

    // back-to-back reads across all ports
    m_rdt = {32'hC, 32'hB, 32'hA};
    cyc(); s_vld = 1'b1; s_adr = 32'h0000_0000; #1;
    chk("b2b_mvld0", {29'b0, m_vld}, 32'h1);
    cyc(); s_adr = 32'h1000_0000; #1;
    chk("b2b_mvld1", {29'b0, m_vld}, 32'h2);
    cyc(); s_adr = 32'h2000_0000; #1;
    chk("b2b_mvld2", {29'b0, m_vld}, 32'h4);
    chk("b2b_rdt0", s_rdt, 32'hA);
    cyc(); s_vld = 1'b0; #1;
    chk("b2b_rdt1", s_rdt, 32'hB);
    cyc(); #1;
    chk("b2b_rdt2", s_rdt, 32'hC);
    cyc(); #1;
    chk("b2b_idle", s_rdt, 32'h0);

    // unmapped read: accepted at once, error response
    cyc(); s_vld = 1'b1; s_adr = 32'h3000_0000; #1;
    chk("miss_mvld", {29'b0, m_vld}, 32'h0);
    chk("miss_rdy", {31'b0, s_rdy}, 32'h1);
    cyc(); s_vld = 1'b0; #1;
    chk("miss_early", {31'b0, s_err}, 32'h0);
    cyc(); #1;
    chk("miss_err", {31'b0, s_err}, 32'h1);
    chk("miss_rdt", s_rdt, 32'h0);

    // overlapping map: lowest index wins, port 1 catches the rest
    cyc(); s_vld = 1'b1; s_adr = 32'h0000_0010; #1;
    chk("ovl_low", {29'b0, o_vld}, 32'h1);
    s_adr = 32'h3000_0000; #1;
    chk("ovl_catch", {29'b0, o_vld}, 32'h2);
    chk("ovl_rdy", {31'b0, o_rdy}, 32'h1);
    s_vld = 1'b0;

    // flush two cycles so the pipeline is empty
    cyc(); cyc();

    // port 2 stalls three cycles while an earlier port 0 response completes
    m_rdt = {32'h5555_0002, 32'hB, 32'hA};
    cyc(); s_vld = 1'b1; s_adr = 32'h0000_0020; #1;
    chk("stl_c0_rdy", {31'b0, s_rdy}, 32'h1);
    cyc(); s_adr = 32'h2000_0000; m_rdy = 3'b011; #1;
    chk("stl_c1_rdy", {31'b0, s_rdy}, 32'h0);
    chk("stl_c1_mvld", {29'b0, m_vld}, 32'h4);
    cyc(); #1;
    chk("stl_c2_rdy", {31'b0, s_rdy}, 32'h0);
    chk("stl_c2_rdt", s_rdt, 32'hA);
    cyc(); #1;
    chk("stl_c3_rdy", {31'b0, s_rdy}, 32'h0);
    chk("stl_c3_rdt", s_rdt, 32'h0);
    cyc(); m_rdy = 3'b111; #1;
    chk("stl_c4_rdy", {31'b0, s_rdy}, 32'h1);
    chk("stl_c4_rdt", s_rdt, 32'h0);
    cyc(); s_vld = 1'b0; #1;
    chk("stl_c5_rdt", s_rdt, 32'h0);
    chk("stl_c5_err", {31'b0, s_err}, 32'h0);
    cyc(); #1;
    chk("stl_c6_rdt", s_rdt, 32'h5555_0002);

    // write to port 1 that the subordinate rejects
    cyc(); s_vld = 1'b1; s_wen = 1'b1; s_adr = 32'h1000_0008; #1;
    chk("wr_mwen", {31'b0, m_wen}, 32'h1);
    cyc(); s_vld = 1'b0; s_wen = 1'b0; m_err[1] = 1'b1; #1;
    cyc(); #1;
    chk("wr_err", {31'b0, s_err}, 32'h1);
    cyc(); m_err[1] = 1'b0; #1;
    chk("wr_after", {31'b0, s_err}, 32'h0);

    // reset one cycle after a transfer drops its response
    m_rdt[1] = 32'hDEAD_BEEF;
    cyc(); s_vld = 1'b1; s_adr = 32'h1000_0000; #1;
    cyc(); s_vld = 1'b0; rst = 1'b1; #1;
    cyc(); rst = 1'b0; m_err[1] = 1'b1; #1;
    chk("rstd_rdt", s_rdt, 32'h0);
    chk("rstd_err", {31'b0, s_err}, 32'h0);

    // reset coinciding with a transfer records nothing
    cyc(); s_vld = 1'b1; rst = 1'b1; #1;
    cyc(); s_vld = 1'b0; rst = 1'b0; #1;
    cyc(); #1;
    chk("rstx_err", {31'b0, s_err}, 32'h0);
    m_err[1] = 1'b0;

    // normal read after reset
    cyc(); s_vld = 1'b1; s_adr = 32'h1000_0000; #1;
    cyc(); s_vld = 1'b0; #1;
    cyc(); #1;
    chk("post_rdt", s_rdt, 32'hDEAD_BEEF);
    chk("post_err", {31'b0, s_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
